// File: rtl/tqvp_bus_pkg.sv
// rtl/tqvp_bus_pkg.sv - shared size encodings, FSM states and data masking for the TinyQV peripheral bus
package tqvp_bus_pkg;

  localparam logic [1:0] SIZE_8      = 2'b00;
  localparam logic [1:0] SIZE_16     = 2'b01;
  localparam logic [1:0] SIZE_32     = 2'b10;
  localparam logic [1:0] STROBE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_e;

  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_8:  return {24'd0, data[7:0]};
      SIZE_16: return {16'd0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// rtl/tqvp_bus_initiator.sv - single-transaction TinyQV peripheral bus master with valid/ready command and response ports
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  per_address,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= STROBE_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          size_d  = cmd_size;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_size == STROBE_NONE) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = cmd_write ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      ST_READ: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving in the final wait cycle still counts as success.
        if (per_data_ready) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = size_mask(size_q, per_data_out);
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign rsp_valid        = (state_q == ST_RESP);
  assign rsp_rdata        = rdata_q;
  assign rsp_err          = err_q;
  assign per_address      = addr_q;
  assign per_data_in      = wdata_q;
  assign per_data_write_n = (state_q == ST_WRITE) ? size_q : STROBE_NONE;
  assign per_data_read_n  = (state_q == ST_READ)  ? size_q : STROBE_NONE;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// tb/tb_tqvp_bus_initiator.sv - randomized bench for tqvp_bus_initiator against a transaction-timeline model
module tb_tqvp_bus_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_size = 2'b00;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  per_address;
  logic [31:0] per_data_in;
  logic [1:0]  per_data_write_n;
  logic [1:0]  per_data_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready;

  tqvp_bus_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .per_address(per_address), .per_data_in(per_data_in),
    .per_data_write_n(per_data_write_n), .per_data_read_n(per_data_read_n),
    .per_data_out(per_data_out), .per_data_ready(per_data_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle-time %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_mask(input logic [1:0] size, input logic [31:0] w);
    int bits;
    bits = 8 << size;
    if (bits >= 32) return w;
    return w % (32'd1 << bits);
  endfunction

  // Model: for each accepted command, the cycles on which strobes and the response must appear.
  int          cyc = 0;
  logic [31:0] mem [64];
  logic        busy;
  int          acc_cnt, acc_cyc, wr_cyc, rd_first, rd_last, rsp_start, ready_cyc;
  logic [1:0]  m_size;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rdata, rd_word;
  logic        m_err;
  int          drv_k = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      ready_cyc <= -1;
      acc_cnt   <= acc_cnt;
    end else if (busy && cyc >= rsp_start && rsp_ready) begin
      busy <= 1'b0;
    end else if (!busy && cmd_valid) begin
      busy      <= 1'b1;
      acc_cnt   <= acc_cnt + 1;
      acc_cyc   <= cyc;
      m_size    <= cmd_size;
      m_addr    <= cmd_addr;
      m_wdata   <= cmd_wdata;
      wr_cyc    <= -1;
      rd_first  <= 1;
      rd_last   <= 0;
      ready_cyc <= -1;
      m_rdata   <= '0;
      m_err     <= 1'b0;
      rd_word   <= mem[cmd_addr];
      if (cmd_size == 2'b11) begin
        rsp_start <= cyc + 1;
        m_err     <= 1'b1;
      end else if (cmd_write) begin
        wr_cyc         <= cyc + 1;
        rsp_start      <= cyc + 2;
        mem[cmd_addr]  <= cmd_wdata;
      end else begin
        rd_first <= cyc + 1;
        if (drv_k >= 1 && drv_k <= TO) begin
          rd_last   <= cyc + drv_k;
          ready_cyc <= cyc + drv_k;
          rsp_start <= cyc + drv_k + 1;
          m_rdata   <= expect_mask(cmd_size, mem[cmd_addr]);
        end else begin
          rd_last   <= cyc + TO;
          rsp_start <= cyc + TO + 1;
          m_err     <= 1'b1;
        end
      end
    end
  end

  initial acc_cnt = 0;

  assign per_data_ready = busy && (cyc == ready_cyc) && (per_data_read_n != 2'b11);
  assign per_data_out   = (busy && cyc == ready_cyc) ? rd_word : ~rd_word;

  int wr_strobes = 0;
  int rd_strobes = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_write_n", 32'(per_data_write_n), 32'h3);
      chk("rst_read_n", 32'(per_data_read_n), 32'h3);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_per_address", 32'(per_address), 32'h0);
      chk("rst_per_data_in", per_data_in, 32'h0);
    end else begin
      if (per_data_write_n != 2'b11) wr_strobes++;
      if (per_data_read_n != 2'b11) rd_strobes++;
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      chk("write_n", 32'(per_data_write_n), (busy && cyc == wr_cyc) ? 32'(m_size) : 32'h3);
      chk("read_n", 32'(per_data_read_n),
          (busy && cyc >= rd_first && cyc <= rd_last) ? 32'(m_size) : 32'h3);
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && cyc >= rsp_start));
      chk("per_address", 32'(per_address), 32'(m_addr));
      chk("per_data_in", per_data_in, m_wdata);
      if (busy && cyc >= rsp_start) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // rsp_ready driver: 0 = held low, 1 = held high, 2 = random each cycle.
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = (rdy_mode == 2) ? 1'($urandom % 2) : rdy_mode[0];
  end

  task automatic do_cmd(input logic w, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd,
                        input int k, output logic [31:0] rdata, output logic err, output int lat,
                        output int nw, output int nr);
    int a0, w0, r0;
    bit ok;
    rdata = '0; err = 1'b0; lat = -1;
    @(posedge clk); #2;
    cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = wd; drv_k = k; cmd_valid = 1'b1;
    a0 = acc_cnt; w0 = wr_strobes; r0 = rd_strobes;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != a0) ok = 1;
    end
    #1 cmd_valid = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          ok = 1; rdata = rsp_rdata; err = rsp_err; lat = cyc - acc_cyc;
        end
      end
      if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(posedge clk); #1;
        if (!busy) ok = 1;
      end
      if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    end
    nw = wr_strobes - w0;
    nr = rd_strobes - r0;
  endtask

  logic [31:0] rd, r0;
  logic        er;
  int          lat, nw, nr, a1, hcyc;
  bit          got;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

    // Watchdog-style write then read back.
    do_cmd(1'b1, 2'b10, 6'd2, 32'h0000_0010, 1, rd, er, lat, nw, nr);
    chk("wd_write_strobes", 32'(nw), 32'd1);
    chk("wd_write_lat", 32'(lat), 32'd2);
    do_cmd(1'b0, 2'b10, 6'd2, 32'h0, 1, rd, er, lat, nw, nr);
    chk("wd_read_data", rd, 32'h0000_0010);
    chk("wd_read_err", 32'(er), 32'd0);
    chk("wd_read_lat", 32'(lat), 32'd2);

    do_cmd(1'b1, 2'b10, 6'd5, 32'hDEAD_BEEF, 1, rd, er, lat, nw, nr);
    do_cmd(1'b0, 2'b00, 6'd5, 32'h0, 2, rd, er, lat, nw, nr);
    chk("read8_data", rd, 32'h0000_00EF);
    chk("read8_lat", 32'(lat), 32'd3);
    do_cmd(1'b0, 2'b01, 6'd5, 32'h0, TO, rd, er, lat, nw, nr);
    chk("read16_last_cycle_data", rd, 32'h0000_BEEF);
    chk("read16_last_cycle_err", 32'(er), 32'd0);

    do_cmd(1'b0, 2'b10, 6'd5, 32'h0, 0, rd, er, lat, nw, nr);
    chk("timeout_strobes", 32'(nr), 32'd4);
    chk("timeout_err", 32'(er), 32'd1);
    chk("timeout_data", rd, 32'd0);
    chk("timeout_lat", 32'(lat), 32'd5);

    do_cmd(1'b1, 2'b11, 6'd7, 32'h1234_5678, 1, rd, er, lat, nw, nr);
    chk("invalid_strobes", 32'(nw + nr), 32'd0);
    chk("invalid_lat", 32'(lat), 32'd1);
    chk("invalid_err", 32'(er), 32'd1);

    // Stalled response: a pending command must wait for the handshake.
    @(posedge clk); #1 rdy_mode = 0;
    #1 cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'd2; drv_k = 1; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("stall_rsp_seen", 32'(got), 32'd1);
    r0 = rsp_rdata;
    a1 = acc_cnt;
    @(posedge clk); #2;
    cmd_write = 1'b1; cmd_size = 2'b00; cmd_addr = 6'd9; cmd_wdata = 32'h55; cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_rdata, r0);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("stall_no_accept", 32'(acc_cnt), 32'(a1));
    @(posedge clk); #1 rdy_mode = 1; hcyc = cyc;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != a1) got = 1;
    end
    #1 cmd_valid = 1'b0;
    chk("b2b_accept_cycle", 32'(acc_cyc), 32'(hcyc + 1));
    repeat (4) @(posedge clk);

    // Reset in the middle of a read wait.
    @(posedge clk); #2;
    cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'd2; drv_k = 0; cmd_valid = 1'b1;
    @(posedge clk); #2 cmd_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midread_rst_read_n", 32'(per_data_read_n), 32'h3);
    chk("midread_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midread_cmd_ready", 32'(cmd_ready), 32'd1);
    do_cmd(1'b0, 2'b10, 6'd2, 32'h0, 2, rd, er, lat, nw, nr);
    chk("post_rst_read", rd, 32'h0000_0010);
    chk("post_rst_err", 32'(er), 32'd0);

    rdy_mode = 2;
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_cmd(1'($urandom % 2), 2'($urandom % 4), 6'($urandom % 16), $urandom,
             int'($urandom_range(0, TO + 1)), rd, er, lat, nw, nr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tqvp_bus_initiator.md
# tqvp_bus_initiator

Initiator for the TinyQV peripheral bus. Accepts one command at a time on a valid/ready command port and drives a single 8/16/32-bit read or write transaction toward one peripheral. Returns the read data or a timeout/error status on a valid/ready response port. It is used for bring-up and for autonomous on-chip sequencing of peripherals such as the watchdog, and it is the master counterpart of every `tqvp_*` responder.

## Interface
- `TIMEOUT`, 16: maximum cycles a read strobe is held waiting for `per_data_ready`; legal range 1..255.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_size` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = invalid.
- `cmd_addr` in 6: peripheral register address.
- `cmd_wdata` in 32: write data; only the low bits for the selected size are significant.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out 32: read data, zero-extended from the selected size; 0 for writes and errors.
- `rsp_err` out 1: 1 = invalid size or read timeout.
- `per_address` out 6: address to peripheral.
- `per_data_in` out 32: write data to peripheral.
- `per_data_write_n` out 2: write strobe/size (11 = none).
- `per_data_read_n` out 2: read strobe/size (11 = none).
- `per_data_out` in 32: peripheral read data.
- `per_data_ready` in 1: peripheral read data valid; may be combinational from `per_data_read_n`.

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - `cmd_ready` = 1; all other states have `cmd_ready` = 0.
  - On `cmd_valid & cmd_ready`, register write, size, addr and wdata.
  - If size = 11, go to RESP with err = 1 and rdata = 0. No bus activity.
  - Otherwise go to WRITE if write, else READ.
- WRITE:
  - `per_data_write_n` = registered size for exactly one cycle.
  - Go to RESP with err = 0 and rdata = 0. Writes are fire-and-forget; `per_data_ready` is ignored.
- READ:
  - `per_data_read_n` = registered size every cycle in this state.
  - Wait counter starts at 0 on entry and increments each READ cycle.
  - If `per_data_ready` = 1 in a cycle, capture `per_data_out` masked to size (8 → [7:0], 16 → [15:0], 32 → all), zero-extended. Go to RESP with err = 0.
  - Else if the counter equals TIMEOUT-1, go to RESP with err = 1 and rdata = 0.
  - Data-ready wins over timeout in the same cycle.
- RESP:
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- `per_address` and `per_data_in` come from the registered command and are held between transactions.
- `per_data_in` carries the full 32-bit `cmd_wdata` unmasked; the size field qualifies it.
- Outside WRITE and READ, both strobes are 11.
- Reset at any time, including mid-READ or mid-RESP:
  - state = IDLE, counter = 0;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0;
  - strobes = 11; `per_address` = 0, `per_data_in` = 0;
  - `cmd_ready` = 1 after reset release.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from `cmd_*` or `per_*` inputs to outputs.
- Write accepted in cycle N: strobe in cycle N+1, `rsp_valid` from N+2.
- Read accepted in N with a same-cycle responder: strobe in N+1, data captured at the end of N+1, `rsp_valid` from N+2.
- Read whose responder asserts ready in its k-th strobe cycle (k ≤ TIMEOUT): `rsp_valid` from N+1+k.
- Timeout: strobe held for exactly TIMEOUT cycles (N+1..N+TIMEOUT), `rsp_valid` with err from N+TIMEOUT+1.
- Invalid size: `rsp_valid` from N+1, with no strobe.
- Back-to-back: with `rsp_ready` held high, the next command is accepted in the cycle after the response handshake. Minimum write-to-write spacing is 3 cycles.

## Structure
- Package `tqvp_bus_pkg` holds:
  - size constants `SIZE_8`, `SIZE_16`, `SIZE_32` and `STROBE_NONE` = 2'b11;
  - the state enum;
  - function `size_mask(size, data)` returning the zero-extended masked word.
- `tqvp_*` responders reuse these constants.
- No sub-module; single flat FSM plus counter and command/response registers.

## Test plan
- Watchdog as target: write size 10, addr 2, data 0x0000_0010, then read size 10, addr 2 → exactly one write strobe of 10, then `rsp_rdata` = 0x0000_0010, err = 0.
- Read size 00 from a responder returning 0xDEAD_BEEF → `rsp_rdata` = 0x0000_00EF. Read size 01 → 0x0000_BEEF.
- Responder never asserts ready, TIMEOUT = 4 → read strobe high for exactly 4 cycles, then `rsp_valid` with err = 1 and rdata = 0.
- `cmd_size` = 11 → no strobe ever leaves 11, response arrives 1 cycle after accept with err = 1.
- Hold `rsp_ready` low for 5 cycles → `rsp_valid` and data stay stable, `cmd_ready` stays 0, and a new `cmd_valid` is not accepted.
- Assert `rst_n` low during READ wait → strobes return to 11 immediately, `rsp_valid` = 0, `cmd_ready` = 1 after release, and the next command completes normally.
